cpu_boot_writer: RTL and testbench
==================================

// Module: cpu_boot_writer
// PURPOSE
//  Loads a boot image into the CPU boot memory (1024 x 32) from a byte stream (UART RX or debug link).
//  It is the write side of the boot memory, which the CPU reads synchronously on its own port.
//  It parses a framed image, packs bytes into little-endian 32-bit words and writes them sequentially from address 0.
//  It holds the CPU in reset while a load is in progress or after a failed load.
// PARAMETERS
//  addr_width  10    boot memory word-address width; capacity = 2**addr_width words
//  data_width  32    memory word width; fixed at 32 (4 bytes per word)
//  MAGIC       8'hA5 frame start byte
// PORTS
//  clk_i       in   1           system clock (single domain)
//  rst_ni      in   1           reset, asynchronous, active-low
//  rx_data_i   in   8           stream byte
//  rx_valid_i  in   1           byte valid; a byte is accepted when rx_valid_i && rx_ready_o
//  rx_ready_o  in/out: out 1    byte accept
//  mem_we_o    out  1           boot memory write strobe, one cycle per word
//  mem_addr_o  out  addr_width  word address
//  mem_data_o  out  data_width  word data, byte 0 of the word in bits [7:0]
//  cpu_hold_o  out  1           hold CPU in reset
//  done_o      out  1           last load completed with a good checksum (level)
//  error_o     out  1           last load failed (level)
// BEHAVIOUR
//  Reset values: rx_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_hold_o=0, done_o=0, error_o=0, state=IDLE.
//  rx_ready_o=1 in every state after reset and is registered. No backpressure is ever applied.
//  Frame format: MAGIC, LEN_LO, LEN_HI, then 4*LEN payload bytes, then CSUM.
//   LEN is the word count. CSUM = 8-bit sum mod 256 of all payload bytes.
//  States and transitions (one accepted byte per transition):
//   IDLE: MAGIC -> LEN_LO; set cpu_hold_o=1; clear done_o and error_o. Any other byte is ignored.
//   LEN_LO: store the byte -> LEN_HI.
//   LEN_HI: form LEN. LEN==0 or LEN>2**addr_width -> ERROR; otherwise -> DATA with word counter=0.
//   DATA: pack bytes in order 0..3. On the 4th byte -> issue a write; counter+1; byte index wraps to 0.
//     After word LEN-1 is written -> CSUM.
//   CSUM: match -> DONE; mismatch -> ERROR.
//   DONE: cpu_hold_o=0, done_o=1. MAGIC -> LEN_LO, which starts a new load. Other bytes are ignored.
//   ERROR: cpu_hold_o stays 1, error_o=1. MAGIC -> LEN_LO. Other bytes are ignored.
//  Write timing: 4th byte of word k accepted at edge N.
//   -> mem_we_o=1 for exactly cycle N+1, with mem_addr_o=k and mem_data_o=the packed word.
//   -> mem_we_o=0 at N+2.
//   Back-to-back words (one byte per cycle) give a write every 4th cycle; writes never overlap.
//  Checksum accumulator is 8 bits wide and wraps. The word counter is addr_width+1 bits, so LEN==2**addr_width is legal.
//  The last write goes to address 2**addr_width-1. The address never wraps to 0 within a load.
//  MAGIC inside LEN/DATA/CSUM is plain data. There is no resync mid-frame.
//  Simultaneous events: the last data byte and its write are handled as above. The CSUM byte may arrive in the cycle of the last write.
//   The outcome (DONE/ERROR) registers at the edge after CSUM is accepted.
//  Reset mid-load: async return to IDLE with cpu_hold_o=0. Memory contents are left partially written.
//   System-level reset also resets the CPU, which then runs the existing memory image.
//  The block must never write memory while in IDLE, DONE or ERROR.
// STRUCTURE
//  Shared package boot_writer_pkg holds:
//   - boot_state_t enum {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR}
//   - localparam BOOT_MAGIC = 8'hA5
//   - localparam BYTES_PER_WORD = 4
//  One sub-module is natural: boot_word_packer, a byte-index counter plus a 32-bit shift/insert register.
//   It produces a word_valid pulse and the packed word.
//  The FSM, counters and checksum live in the top. All outputs are registered.
// TESTING
//  1) Frame A5 02 00 | 11 22 33 44 | 55 66 77 88 | CSUM=0x64
//     -> writes addr0=0x44332211, addr1=0x88776655; done_o=1; cpu_hold_o 1 then 0; error_o=0.
//  2) Same frame with CSUM=0x65
//     -> both writes still occur; error_o=1; cpu_hold_o stays 1; done_o=0.
//  3) LEN=0x0000, and separately LEN=0x0401
//     -> ERROR immediately after LEN_HI; zero mem_we_o pulses.
//  4) Full-size LEN=0x0400 streamed at one byte per cycle
//     -> 1024 writes, addresses 0..1023 in order, each mem_we_o exactly 1 cycle, no address wrap; DONE.
//  5) Junk bytes 00 FF 5A before A5, plus rx_valid_i gaps of 0..7 cycles between bytes
//     -> junk ignored; results identical to test 1.
//  6) rst_ni low for 1 cycle mid-DATA after word 0 is written
//     -> all outputs return to reset values asynchronously.
//     A fresh frame then loads correctly from addr 0.

Source files
------------

// File: rtl/boot_writer_pkg.sv
// Shared types and constants for the boot image writer.
package boot_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC     = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted bytes into little-endian 32-bit words; word_valid_o pulses
// for one cycle after the fourth byte is taken.
module boot_word_packer
    import boot_writer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;

    assign word_last_o = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= '0;
            low_q        <= '0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
        end else begin
            word_valid_o <= word_last_o;
            if (clear_i) begin
                idx_q <= '0;
            end else if (byte_valid_i) begin
                case (idx_q)
                    2'd0:    low_q[7:0]   <= byte_i;
                    2'd1:    low_q[15:8]  <= byte_i;
                    2'd2:    low_q[23:16] <= byte_i;
                    default: ;
                endcase
                // Index wraps naturally to 0 after the top byte.
                idx_q <= idx_q + 2'd1;
                if (word_last_o) begin
                    word_o <= {byte_i, low_q};
                end
            end
        end
    end

endmodule

// File: rtl/cpu_boot_writer.sv
// Framed byte-stream loader for the CPU boot memory; holds the CPU in reset
// while loading and after a failed load.
//
//  state  | meaning
//  IDLE   | waiting for MAGIC after reset, other bytes dropped
//  LEN_LO | expecting low byte of word count
//  LEN_HI | expecting high byte, word count checked here
//  DATA   | payload bytes packed and written word by word
//  CSUM   | expecting checksum byte
//  DONE   | good image loaded, CPU released
//  ERROR  | bad length or checksum, CPU kept in reset
module cpu_boot_writer
    import boot_writer_pkg::*;
#(
    parameter int         addr_width = 10,
    parameter int         data_width = 32,
    parameter logic [7:0] MAGIC      = BOOT_MAGIC
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  mem_we_o,
    output logic [addr_width-1:0] mem_addr_o,
    output logic [data_width-1:0] mem_data_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [addr_width:0] CNT_ONE = 1;

    boot_state_t state_q, state_d;

    logic                  rx_ready_q;
    logic                  acc;
    logic                  is_magic;
    logic                  start;
    logic [7:0]            len_lo_q;
    logic [15:0]           len_full;
    logic                  len_bad;
    logic [addr_width:0]   len_q;
    logic [addr_width:0]   word_cnt_q;
    logic                  last_word;
    logic [7:0]            csum_q;
    logic [addr_width-1:0] addr_q;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  pk_valid;
    logic                  pk_last;
    logic                  pk_word_valid;
    logic [31:0]           pk_word;

    assign acc       = rx_valid_i && rx_ready_q;
    assign is_magic  = (rx_data_i == MAGIC);
    assign start     = acc && is_magic &&
                       (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign len_full  = {rx_data_i, len_lo_q};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > (32'd1 << addr_width));
    assign last_word = ((word_cnt_q + CNT_ONE) == len_q);
    assign pk_valid  = acc && (state_q == DATA);

    boot_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (start),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_data_i),
        .word_last_o  (pk_last),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            case (state_q)
                IDLE, DONE, ERROR: if (is_magic) state_d = LEN_LO;
                LEN_LO:            state_d = LEN_HI;
                LEN_HI:            state_d = len_bad ? ERROR : DATA;
                DATA:              if (pk_last && last_word) state_d = CSUM;
                CSUM:              state_d = (rx_data_i == csum_q) ? DONE : ERROR;
                default:           state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hold_d = hold_q;
        done_d = done_q;
        err_d  = err_q;
        if (acc) begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (is_magic) begin
                        hold_d = 1'b1;
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
                end
                LEN_HI: if (len_bad) err_d = 1'b1;
                CSUM: begin
                    if (rx_data_i == csum_q) begin
                        hold_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_ready_q <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (start) begin
                csum_q     <= '0;
                word_cnt_q <= '0;
            end
            if (acc && state_q == LEN_LO) len_lo_q <= rx_data_i;
            if (acc && state_q == LEN_HI) len_q <= len_full[addr_width:0];
            if (pk_valid) begin
                csum_q <= csum_q + rx_data_i;
                // Address is latched with the word so it lines up with the packer's pulse.
                if (pk_last) begin
                    addr_q     <= word_cnt_q[addr_width-1:0];
                    word_cnt_q <= word_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign mem_we_o   = pk_word_valid;
    assign mem_addr_o = addr_q;
    assign mem_data_o = pk_word;
    assign cpu_hold_o = hold_q;
    assign done_o     = done_q;
    assign error_o    = err_q;

endmodule

// File: tb/tb_cpu_boot_writer.sv
// Self-checking bench for cpu_boot_writer against a frame-level reference model.
module tb_cpu_boot_writer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    logic [9:0]  cap_addr[$];
    logic [31:0] cap_data[$];
    logic        prev_we = 1'b0;

    logic [7:0]  frm[$];
    logic [31:0] exp_words[$];
    bit          exp_done;
    bit          exp_err;

    cpu_boot_writer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .cpu_hold_o (cpu_hold_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every write; a strobe high on two consecutive cycles is an overlap.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            cap_addr.push_back(mem_addr_o);
            cap_data.push_back(mem_data_o);
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_pulse_width: addr %0d strobe high for 2+ cycles, required 1", mem_addr_o);
            end
        end
        prev_we = mem_we_o;
    end

    task automatic model(input logic [7:0] f[$]);
        int i = 0;
        int len;
        int p;
        logic [7:0] sum = 8'h00;
        exp_words.delete();
        while (i < f.size() && f[i] != 8'hA5) i++;
        len = int'(f[i+1]) + 256 * int'(f[i+2]);
        if (len == 0 || len > 1024) begin
            exp_done = 0;
            exp_err  = 1;
            return;
        end
        p = i + 3;
        for (int w = 0; w < len; w++) begin
            exp_words.push_back({f[p+3], f[p+2], f[p+1], f[p]});
            for (int k = 0; k < 4; k++) sum += f[p+k];
            p += 4;
        end
        exp_done = (f[p] == sum);
        exp_err  = !exp_done;
    endtask

    task automatic make_frame(input int len, input bit bad);
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(len[7:0]);
        frm.push_back(len[15:8]);
        for (int k = 0; k < 4 * len; k++) begin
            b = 8'($urandom);
            frm.push_back(b);
            sum += b;
        end
        frm.push_back(bad ? (sum ^ 8'h01) : sum);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk_i);
            rx_valid_i = 1'b0;
        end
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frm[i]) send_byte(frm[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({rx_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                     rx_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (rx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", rx_ready_o);
        end
    endtask

    task automatic test_good_frame;
        logic [7:0] f[] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        cap_addr.delete();
        cap_data.delete();
        foreach (f[i]) begin
            send_byte(f[i], 0);
            if (i == 2) begin
                #1;
                checks++;
                if (cpu_hold_o !== 1'b1 || done_o !== 1'b0) begin
                    errors++;
                    $display("FAIL good_hold_during_load: hold=%b done=%b, required 1 0", cpu_hold_o, done_o);
                end
            end
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (cap_addr.size() != 2) begin
            errors++;
            $display("FAIL good_write_count: got %0d, required 2", cap_addr.size());
        end else begin
            checks++;
            if (cap_addr[0] !== 10'd0 || cap_data[0] !== 32'h44332211) begin
                errors++;
                $display("FAIL good_word0: addr=%0d data=%h, required 0 44332211", cap_addr[0], cap_data[0]);
            end
            checks++;
            if (cap_addr[1] !== 10'd1 || cap_data[1] !== 32'h88776655) begin
                errors++;
                $display("FAIL good_word1: addr=%0d data=%h, required 1 88776655", cap_addr[1], cap_data[1]);
            end
        end
        checks++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
            errors++;
            $display("FAIL good_status: done=%b err=%b hold=%b, required 1 0 0", done_o, error_o, cpu_hold_o);
        end
    endtask

    task automatic test_bad_csum;
        logic [7:0] f[] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        cap_addr.delete();
        cap_data.delete();
        frm.delete();
        foreach (f[i]) frm.push_back(f[i]);
        send_frame(0);
        checks++;
        if (cap_addr.size() != 2) begin
            errors++;
            $display("FAIL badcsum_write_count: got %0d, required 2", cap_addr.size());
        end else begin
            checks++;
            if (cap_data[0] !== 32'h44332211 || cap_data[1] !== 32'h88776655) begin
                errors++;
                $display("FAIL badcsum_data: got %h %h, required 44332211 88776655", cap_data[0], cap_data[1]);
            end
        end
        checks++;
        if (done_o !== 1'b0 || error_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
            errors++;
            $display("FAIL badcsum_status: done=%b err=%b hold=%b, required 0 1 1", done_o, error_o, cpu_hold_o);
        end
    endtask

    task automatic test_bad_len;
        logic [15:0] lens[2] = '{16'h0000, 16'h0401};
        foreach (lens[n]) begin
            cap_addr.delete();
            cap_data.delete();
            frm.delete();
            frm.push_back(8'hA5);
            frm.push_back(lens[n][7:0]);
            frm.push_back(lens[n][15:8]);
            for (int k = 0; k < 8; k++) frm.push_back(8'(k + 1));
            send_frame(0);
            checks++;
            if (cap_addr.size() != 0) begin
                errors++;
                $display("FAIL badlen_writes: len=%h got %0d writes, required 0", lens[n], cap_addr.size());
            end
            checks++;
            if (error_o !== 1'b1 || done_o !== 1'b0 || cpu_hold_o !== 1'b1) begin
                errors++;
                $display("FAIL badlen_status: len=%h err=%b done=%b hold=%b, required 1 0 1",
                         lens[n], error_o, done_o, cpu_hold_o);
            end
        end
    endtask

    task automatic test_full_size;
        int bad_pos = 0;
        cap_addr.delete();
        cap_data.delete();
        make_frame(1024, 0);
        model(frm);
        send_frame(0);
        checks++;
        if (cap_addr.size() != 1024) begin
            errors++;
            $display("FAIL full_write_count: got %0d, required 1024", cap_addr.size());
        end else begin
            for (int i = 0; i < 1024; i++) begin
                checks++;
                if (cap_addr[i] !== 10'(i) || cap_data[i] !== exp_words[i]) begin
                    errors++;
                    if (bad_pos < 4)
                        $display("FAIL full_word: idx %0d addr=%0d data=%h, required %0d %h",
                                 i, cap_addr[i], cap_data[i], i, exp_words[i]);
                    bad_pos++;
                end
            end
        end
        checks++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
            errors++;
            $display("FAIL full_status: done=%b err=%b hold=%b, required 1 0 0", done_o, error_o, cpu_hold_o);
        end
    endtask

    task automatic test_junk_gaps;
        logic [7:0] f[] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                            8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        for (int rep = 0; rep < 3; rep++) begin
            cap_addr.delete();
            cap_data.delete();
            frm.delete();
            foreach (f[i]) frm.push_back(f[i]);
            model(frm);
            send_frame(7);
            checks++;
            if (cap_addr.size() != exp_words.size()) begin
                errors++;
                $display("FAIL junk_write_count: got %0d, required %0d", cap_addr.size(), exp_words.size());
            end else begin
                foreach (exp_words[i]) begin
                    checks++;
                    if (cap_addr[i] !== 10'(i) || cap_data[i] !== exp_words[i]) begin
                        errors++;
                        $display("FAIL junk_word: idx %0d addr=%0d data=%h, required %0d %h",
                                 i, cap_addr[i], cap_data[i], i, exp_words[i]);
                    end
                end
            end
            checks++;
            if (done_o !== exp_done || error_o !== exp_err || cpu_hold_o !== !exp_done) begin
                errors++;
                $display("FAIL junk_status: done=%b err=%b hold=%b, required %b %b %b",
                         done_o, error_o, cpu_hold_o, exp_done, exp_err, !exp_done);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        logic [7:0] f[] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        cap_addr.delete();
        cap_data.delete();
        foreach (f[i]) send_byte(f[i], 0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        checks++;
        if (cap_addr.size() != 1 || cpu_hold_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: writes=%0d hold=%b, required 1 1", cap_addr.size(), cpu_hold_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({rx_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async: ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                     rx_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        cap_addr.delete();
        cap_data.delete();
        frm.delete();
        foreach (f[i]) frm.push_back(f[i]);
        frm.push_back(8'h77);
        frm.push_back(8'h88);
        frm.push_back(8'h64);
        send_frame(0);
        checks++;
        if (cap_addr.size() != 2 || cap_addr[0] !== 10'd0 || cap_data[0] !== 32'h44332211 ||
            cap_addr[1] !== 10'd1 || cap_data[1] !== 32'h88776655) begin
            errors++;
            $display("FAIL midrst_reload: writes=%0d first addr=%0d data=%h, required 2 writes from addr 0",
                     cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 10'h3FF,
                     (cap_data.size() > 0) ? cap_data[0] : 32'hX);
        end
        checks++;
        if (done_o !== 1'b1 || cpu_hold_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_status: done=%b hold=%b, required 1 0", done_o, cpu_hold_o);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 8; n++) begin
            cap_addr.delete();
            cap_data.delete();
            make_frame(int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)));
            model(frm);
            foreach (frm[i]) send_byte(frm[i], (n % 2 == 1) ? int'($urandom_range(0, 3)) : 0);
            @(negedge clk_i);
            rx_valid_i = 1'b0;
            repeat (2) @(negedge clk_i);
            checks++;
            if (cap_addr.size() != exp_words.size()) begin
                errors++;
                $display("FAIL b2b_write_count: frame %0d got %0d, required %0d",
                         n, cap_addr.size(), exp_words.size());
            end else begin
                foreach (exp_words[i]) begin
                    checks++;
                    if (cap_addr[i] !== 10'(i) || cap_data[i] !== exp_words[i]) begin
                        errors++;
                        $display("FAIL b2b_word: frame %0d idx %0d addr=%0d data=%h, required %0d %h",
                                 n, i, cap_addr[i], cap_data[i], i, exp_words[i]);
                    end
                end
            end
            checks++;
            if (done_o !== exp_done || error_o !== exp_err || cpu_hold_o !== !exp_done) begin
                errors++;
                $display("FAIL b2b_status: frame %0d done=%b err=%b hold=%b, required %b %b %b",
                         n, done_o, error_o, cpu_hold_o, exp_done, exp_err, !exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_full_size();
        test_junk_gaps();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
